// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed BCD display scanner.
// Used by seg_scan_ctrl and seg_tick_gen.
package seg_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } state_e;

    localparam bcd_t BCD_MAX = 4'd9;

    // Codes above 9 have no decimal glyph and are shown as 0.
    function automatic bcd_t bcd_sanitize(input bcd_t nib);
        return (nib > BCD_MAX) ? 4'd0 : nib;
    endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Digit dwell prescaler: counts DIV cycles while enabled and pulses tick_o
// on the last one; holds at zero while disabled.
module seg_tick_gen #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed BCD digit scanner with shadow-register load handshake.
// Optional leading-zero blanking is built when SEG_LZB_EN is defined.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    blank,
    output logic                    frame_done,
    output logic                    bad_digit
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    logic                    ready_q;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
    bcd_t                    bcd_q, bcd_d;
    logic                    frame_q, frame_d;
    logic                    bad_q, bad_d;

    logic                    tick;
    logic                    handshake;
    logic                    lzb_hit;
    logic [4*NUM_DIGITS-1:0] load_clean;
    logic [NUM_DIGITS-1:0]   load_bad;
    bcd_t                    disp_nib [NUM_DIGITS];

    seg_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (state_q == DRIVE),
        .tick_o (tick)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign load_clean[gi*4 +: 4] = bcd_sanitize(load_data[gi*4 +: 4]);
            assign load_bad[gi]          = (load_data[gi*4 +: 4] > BCD_MAX);
            assign disp_nib[gi]          = disp_d[gi*4 +: 4];
        end
    endgenerate

    // ready_q is 0 whenever pending is set, so accept and commit are exclusive.
    assign handshake = load_valid && ready_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        disp_d    = disp_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        frame_d   = 1'b0;
        bad_d     = 1'b0;

        case (state_q)
            GUARD: begin
                state_d = DRIVE;
                // frame_q marks the guard slot that follows the last digit.
                if (frame_q && pending_q) begin
                    disp_d    = shadow_q;
                    pending_d = 1'b0;
                end
            end
            DRIVE: begin
                if (tick) begin
                    state_d = GUARD;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        frame_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = GUARD;
        endcase

        if (handshake) begin
            shadow_d  = load_clean;
            pending_d = 1'b1;
            bad_d     = |load_bad;
        end
    end

`ifdef SEG_LZB_EN
    logic [NUM_DIGITS:0] lead_zero;
    logic                blank_q;

    assign lead_zero[NUM_DIGITS] = 1'b1;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
            assign lead_zero[gi] = lead_zero[gi+1] && (disp_nib[gi] == 4'd0);
        end
    endgenerate

    // Digit 0 is always lit so a zero value still reads "0".
    assign lzb_hit = (idx_d != '0) && lead_zero[idx_d];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= 1'b0;
        end else begin
            blank_q <= (state_d == DRIVE) && lzb_hit;
        end
    end

    assign blank = blank_q;
`else
    assign lzb_hit = 1'b0;
    assign blank   = 1'b0;
`endif

    // Outputs are derived from the next state so they register in step with it.
    always_comb begin
        digit_en_d = '0;
        bcd_d      = '0;
        if ((state_d == DRIVE) && !lzb_hit) begin
            digit_en_d = NUM_DIGITS'(1) << idx_d;
            bcd_d      = disp_nib[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= GUARD;
            idx_q      <= '0;
            disp_q     <= '0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            ready_q    <= 1'b1;
            digit_en_q <= '0;
            bcd_q      <= '0;
            frame_q    <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            ready_q    <= ~pending_d;
            digit_en_q <= digit_en_d;
            bcd_q      <= bcd_d;
            frame_q    <= frame_d;
            bad_q      <= bad_d;
        end
    end

    assign load_ready = ready_q;
    assign digit_en   = digit_en_q;
    assign bcd_out    = bcd_q;
    assign frame_done = frame_q;
    assign bad_digit  = bad_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (4 digits, dwell 4): stimulus queues the
// expected value of each checked frame and bad_digit flag; a monitor compares.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int DV = 4;
    localparam int FRAME_LAST = ND * (DV + 1) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_valid = 1'b0;
    logic [15:0]   load_data = '0;
    logic          load_ready;
    logic [3:0]    bcd_out;
    logic [ND-1:0] digit_en;
    logic          blank;
    logic          frame_done;
    logic          bad_digit;

    int checks = 0;
    int errors = 0;

    logic [15:0] frame_exp_q [$];
    logic        bad_exp_q   [$];

    seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .DIV        (DV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .bcd_out    (bcd_out),
        .digit_en   (digit_en),
        .blank      (blank),
        .frame_done (frame_done),
        .bad_digit  (bad_digit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: position-in-frame model checks every cycle of a queued frame.
    initial begin
        int          p;
        logic        chk_on;
        logic        hs_seen;
        logic [15:0] cur;
        int          slot;
        int          w;
        logic        blanked;
        logic [3:0]  exp_en;
        logic [3:0]  exp_bcd;
        p = 0; chk_on = 1'b0; hs_seen = 1'b0; cur = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk_on  = 1'b0;
                hs_seen = 1'b0;
            end else begin
                if (hs_seen) begin
                    if (bad_exp_q.size() == 0) check("bad_queue_empty", 32'd1, 32'd0);
                    else check("bad_digit", bad_digit, bad_exp_q.pop_front());
                end else begin
                    check("bad_idle", bad_digit, 1'b0);
                end
                hs_seen = load_valid && load_ready;

                if (frame_done) begin
                    if (chk_on) check("frame_len", p, FRAME_LAST);
                    if (frame_exp_q.size() > 0) begin
                        cur    = frame_exp_q.pop_front();
                        chk_on = 1'b1;
                        p      = 0;
                    end else begin
                        chk_on = 1'b0;
                    end
                end else if (chk_on) begin
                    p++;
                    if (p > FRAME_LAST) begin
                        check("frame_len", p, FRAME_LAST);
                        chk_on = 1'b0;
                    end else begin
                        slot = (p - 1) / (DV + 1);
                        w    = (p - 1) % (DV + 1);
`ifdef SEG_LZB_EN
                        blanked = (slot > 0) && ((cur >> (4 * slot)) == 16'd0);
`else
                        blanked = 1'b0;
`endif
                        if (w == DV) begin
                            exp_en = 4'd0; exp_bcd = 4'd0; blanked = 1'b0;
                        end else if (blanked) begin
                            exp_en = 4'd0; exp_bcd = 4'd0;
                        end else begin
                            exp_en  = 4'd1 << slot;
                            exp_bcd = 4'((cur >> (4 * slot)) & 16'hF);
                        end
                        check($sformatf("v%04h_p%0d_en", cur, p), digit_en, exp_en);
                        check($sformatf("v%04h_p%0d_bcd", cur, p), bcd_out, exp_bcd);
                        check($sformatf("v%04h_p%0d_blank", cur, p), blank, blanked);
                    end
                end
            end
        end
    end

    task automatic wait_frame(input logic do_push, input logic [15:0] v);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!frame_done && n < 100);
        check("frame_timeout", frame_done, 1'b1);
        if (frame_done && do_push) frame_exp_q.push_back(v);
    endtask

    task automatic do_load(input logic [15:0] d, input logic exp_bad);
        logic rdy;
        int   n = 0;
        bad_exp_q.push_back(exp_bad);
        load_data  = d;
        load_valid = 1'b1;
        do begin
            rdy = load_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 100);
        load_valid = 1'b0;
        check("load_timeout", rdy, 1'b1);
        $display("load %04h accepted", d);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #2;
        check("rst_en", digit_en, 4'd0);
        check("rst_bcd", bcd_out, 4'd0);
        check("rst_ready", load_ready, 1'b1);
        check("rst_frame", frame_done, 1'b0);
        check("rst_bad", bad_digit, 1'b0);
        check("rst_blank", blank, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_en", digit_en, 4'b0001);
        check("rel_bcd", bcd_out, 4'd0);
        check("rel_frame", frame_done, 1'b0);

        do_load(16'h1234, 1'b0);
        wait_frame(1'b1, 16'h1234);

        fork
            begin
                do_load(16'h1111, 1'b0);
                check("ready_after_load", load_ready, 1'b0);
                do_load(16'h2222, 1'b0);
            end
            begin
                wait_frame(1'b1, 16'h1111);
                wait_frame(1'b1, 16'h2222);
            end
        join

        do_load(16'h12A4, 1'b1);
        wait_frame(1'b1, 16'h1204);
        wait_frame(1'b1, 16'h1204);
        // Accepted inside a non-pending commit cycle: shown one wrap later.
        do_load(16'h5678, 1'b0);
        wait_frame(1'b1, 16'h5678);
        do_load(16'h0070, 1'b0);
        wait_frame(1'b1, 16'h0070);
        do_load(16'h0000, 1'b0);
        wait_frame(1'b1, 16'h0000);

        do_load(16'h9999, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_en", digit_en, 4'd0);
        check("midrst_bcd", bcd_out, 4'd0);
        check("midrst_ready", load_ready, 1'b1);
        check("midrst_frame", frame_done, 1'b0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rerel_en", digit_en, 4'b0001);
        check("rerel_bcd", bcd_out, 4'd0);
        check("rerel_ready", load_ready, 1'b1);
        wait_frame(1'b1, 16'h0000);
        wait_frame(1'b0, 16'h0000);
        @(negedge clk);

        check("frame_queue_left", frame_exp_q.size(), 0);
        check("bad_queue_left", bad_exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
